// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 memory-instruction sequencer.
// Contents: opcodes, FSM state codes, addr2 select codes, ACV bounds.
package lc3_pkg;

   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_LDI = 4'hA;
   localparam logic [3:0] OP_LDR = 4'h6;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_STI = 4'hB;
   localparam logic [3:0] OP_STR = 4'h7;
   localparam logic [3:0] OP_LEA = 4'hE;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CALC   = 3'd1;
   localparam logic [2:0] S_IND    = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_FAULT  = 3'd6;

   localparam logic [1:0] A2_ZERO  = 2'd0;
   localparam logic [1:0] A2_OFF6  = 2'd1;
   localparam logic [1:0] A2_OFF9  = 2'd2;
   localparam logic [1:0] A2_OFF11 = 2'd3;

   localparam logic [15:0] ACV_LO_DEF = 16'h3000;
   localparam logic [15:0] ACV_HI_DEF = 16'hFE00;

   function automatic logic is_mem_op(input logic [3:0] op);
      return (op == OP_LD) || (op == OP_LDI) || (op == OP_LDR) ||
             (op == OP_ST) || (op == OP_STI) || (op == OP_STR) ||
             (op == OP_LEA);
   endfunction

   function automatic logic is_store_op(input logic [3:0] op);
      return (op == OP_ST) || (op == OP_STI) || (op == OP_STR);
   endfunction

   function automatic logic is_indirect_op(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_STI);
   endfunction

   function automatic logic is_base_op(input logic [3:0] op);
      return (op == OP_LDR) || (op == OP_STR);
   endfunction

endpackage

// File: rtl/lc3_acv_check.sv
// User-mode access-violation detector: flags addresses outside [ACV_LO, ACV_HI).
module lc3_acv_check
   import lc3_pkg::*;
#(
   parameter logic [15:0] ACV_LO = ACV_LO_DEF,
   parameter logic [15:0] ACV_HI = ACV_HI_DEF
) (
   input  logic [15:0] addr,
   input  logic        priv,
   output logic        violation
);

   assign violation = priv && ((addr < ACV_LO) || (addr >= ACV_HI));

endmodule

// File: rtl/lc3_mem_seq.sv
// LC-3 memory-instruction sequencer: EA selects, MAR/MDR, memory handshake, DR write.
// Define LC3_ACV_EN to enable user-mode access-violation checking (FAULT state).
module lc3_mem_seq
   import lc3_pkg::*;
#(
   parameter logic [15:0] ACV_LO = ACV_LO_DEF,
   parameter logic [15:0] ACV_HI = ACV_HI_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] ir,
   input  logic        psr_priv,
   input  logic [15:0] ea_in,
   output logic        addr1_sel,
   output logic [1:0]  addr2_sel,
   output logic [2:0]  base_addr,
   output logic [2:0]  sr_addr,
   input  logic [15:0] sr_data,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_rd,
   output logic        mem_wr,
   input  logic        mem_ready,
   input  logic [15:0] mem_rdata,
   output logic        dr_we,
   output logic [2:0]  dr_addr,
   output logic [15:0] dr_data,
   output logic        ld_cc,
   output logic        busy,
   output logic        done,
   output logic        illegal,
   output logic        acv
);

   logic [2:0]  state, state_nx;
   logic [15:0] ir_q, mar, mdr;
   logic [3:0]  op;
   logic        is_store;
   logic        addr_fault;
   logic        unused_ir;

   assign op        = ir_q[15:12];
   assign is_store  = is_store_op(op);
   assign unused_ir = ^ir_q[5:0];

`ifdef LC3_ACV_EN
   // The pointer fetched in IND is checked as it arrives, before ACCESS raises a request.
   logic [15:0] chk_addr;
   assign chk_addr = (state == S_IND) ? mem_rdata : ea_in;

   lc3_acv_check #(
      .ACV_LO(ACV_LO),
      .ACV_HI(ACV_HI)
   ) u_acv_check (
      .addr(chk_addr),
      .priv(psr_priv),
      .violation(addr_fault)
   );

   assign acv = (state == S_FAULT);
`else
   logic unused_acv;
   assign unused_acv = ^{ACV_LO, ACV_HI, psr_priv};
   assign addr_fault = 1'b0;
   assign acv        = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (start) state_nx = is_mem_op(ir[15:12]) ? S_CALC : S_DONE;
         S_CALC: begin
            if (op == OP_LEA)           state_nx = S_WB;
            else if (addr_fault)        state_nx = S_FAULT;
            else if (is_indirect_op(op)) state_nx = S_IND;
            else                        state_nx = S_ACCESS;
         end
         S_IND:    if (mem_ready) state_nx = addr_fault ? S_FAULT : S_ACCESS;
         S_ACCESS: if (mem_ready) state_nx = is_store ? S_DONE : S_WB;
         S_WB:     state_nx = S_DONE;
         default:  state_nx = S_IDLE;
      endcase
   end

   // MDR takes the store data on entry to ACCESS so the write data is stable for the whole request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         ir_q  <= 16'h0000;
         mar   <= 16'h0000;
         mdr   <= 16'h0000;
      end else begin
         state <= state_nx;
         if (state == S_IDLE && start) ir_q <= ir;
         if (state == S_CALC) mar <= ea_in;
         if (state == S_IND && mem_ready) mar <= mem_rdata;
         if (state_nx == S_ACCESS && state != S_ACCESS && is_store) mdr <= sr_data;
         if (state == S_ACCESS && mem_ready && !is_store) mdr <= mem_rdata;
      end
   end

   assign addr1_sel = (state == S_CALC) && is_base_op(op);
   assign addr2_sel = (state != S_CALC) ? A2_ZERO :
                      is_base_op(op)    ? A2_OFF6 : A2_OFF9;
   assign base_addr = ir_q[8:6];
   assign sr_addr   = ir_q[11:9];
   assign mem_addr  = mar;
   assign mem_wdata = mdr;
   assign mem_rd    = (state == S_IND) || (state == S_ACCESS && !is_store);
   assign mem_wr    = (state == S_ACCESS) && is_store;
   assign dr_we     = (state == S_WB);
   assign ld_cc     = (state == S_WB) && (op != OP_LEA);
   assign dr_addr   = ir_q[11:9];
   assign dr_data   = (op == OP_LEA) ? mar : mdr;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE) || (state == S_FAULT);
   assign illegal   = (state == S_DONE) && !is_mem_op(op);

endmodule
